// File: rtl/posit_accum_prod_es3_if.sv
// Operand/result bus for the ES=3 product accumulator, plus the shared
// width constants.
//   slave  : accumulator side (takes operands, drives results)
//   master : producer/consumer side
// Bus layout of in_data/out_data (265 bits):
//   [264] sgn, [263:254] scale (two's complement),
//   [253:2] fraction (hidden 1 not stored), [1] inf, [0] zero
package posit_defines_es3;
    localparam int POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES3 = 265;
    localparam int FBITS_ACCUM = 252;
    localparam int ES = 3;
endpackage

interface posit_accum_prod_es3_if;
    import posit_defines_es3::*;

    logic [POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES3-1:0] in_data;
    logic                                              in_valid;
    logic                                              in_last;
    logic                                              in_ready;
    logic [POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES3-1:0] out_data;
    logic                                              out_truncated;
    logic                                              out_valid;
    logic                                              out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_truncated, out_valid
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_truncated, out_valid
    );
endinterface

// File: rtl/posit_accum_prod_es3.sv
// Dot-product accumulator for unpacked ES=3 posit products.
// Each accepted operand walks ALIGN -> ADD -> NORM (one operand per 4 cycles)
// and is summed into an internal accumulator. The operand flagged in_last
// sends the FSM to OUT, where the sum is presented until out_ready.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : posit_accum_prod_es3_if.slave (operand in, result out)
module posit_accum_prod_es3
    import posit_defines_es3::*;
(
    input logic                      clk,
    input logic                      reset,
    posit_accum_prod_es3_if.slave    bus
);

    localparam int W     = POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES3;
    localparam int MW    = FBITS_ACCUM + 1;   // mantissa incl. hidden bit
    localparam int SC_LO = W - 11;            // low bit of the scale field

    typedef enum logic [2:0] {WAIT, ALIGN, ADD, NORM, OUT} state_t;

    state_t state, state_next;

    // latched operand
    logic                 op_sgn, op_inf, op_zero, op_last;
    logic signed [9:0]    op_scale;
    logic [MW-1:0]        op_mant;

    // accumulator
    logic                 acc_sgn, acc_inf, acc_zero, acc_sticky;
    logic signed [9:0]    acc_scale;
    logic [MW-1:0]        acc_mant;

    // ALIGN results
    logic                 al_sa, al_sb, al_inf, al_sticky;
    logic signed [9:0]    al_scale;
    logic [MW-1:0]        al_ma, al_mb;
    logic                 al_sa_d, al_sb_d, al_inf_d, al_sticky_d;
    logic signed [9:0]    al_scale_d;
    logic [MW-1:0]        al_ma_d, al_mb_d;

    // ADD results (sum carries one extra bit)
    logic                 ad_sgn, ad_inf, ad_sticky;
    logic signed [9:0]    ad_scale;
    logic [MW:0]          ad_sum;
    logic                 ad_sgn_d;
    logic [MW:0]          ad_sum_d;

    // NORM results
    logic                 n_sgn, n_inf, n_zero, n_sticky;
    logic signed [11:0]   n_scale;
    logic [MW-1:0]        n_mant;
    logic [8:0]           n_lz;

    logic accept;

    function automatic logic [8:0] lzc(input logic [MW-1:0] v);
        logic found;
        lzc   = '0;
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      lzc   = lzc + 9'd1;
            end
        end
    endfunction

    assign bus.in_ready      = (state == WAIT) & ~reset;
    assign accept            = bus.in_valid & bus.in_ready;
    assign bus.out_valid     = (state == OUT);
    assign bus.out_data      = {acc_sgn, acc_scale, acc_mant[FBITS_ACCUM-1:0], acc_inf, acc_zero};
    assign bus.out_truncated = acc_sticky;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= WAIT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT:    if (accept) state_next = ALIGN;
            ALIGN:   state_next = ADD;
            ADD:     state_next = NORM;
            NORM:    state_next = op_last ? OUT : WAIT;
            OUT:     if (bus.out_ready) state_next = WAIT;
            default: state_next = WAIT;
        endcase
    end

    // ---------------- ALIGN ----------------
    // The smaller-scale addend is shifted right; the larger one is left intact
    // so the ADD stage can compare magnitudes on aligned mantissas alone.
    always_comb begin
        logic              big_s, sml_s;
        logic signed [9:0] big_sc, sml_sc;
        logic [MW-1:0]     big_m, sml_m;
        logic [10:0]       diff;
        logic [2*MW-1:0]   ext;

        big_s = acc_sgn;  big_sc = acc_scale; big_m = acc_mant;
        sml_s = op_sgn;   sml_sc = op_scale;  sml_m = op_mant;
        diff  = '0;
        ext   = '0;

        al_sa_d     = acc_sgn;
        al_sb_d     = acc_sgn;
        al_scale_d  = acc_scale;
        al_ma_d     = acc_mant;
        al_mb_d     = '0;
        al_inf_d    = acc_inf | op_inf;
        al_sticky_d = acc_sticky;

        if (op_zero) begin
            // defaults already pass the accumulator through untouched
        end else if (acc_zero) begin
            al_sa_d    = op_sgn;
            al_sb_d    = op_sgn;
            al_scale_d = op_scale;
            al_ma_d    = op_mant;
        end else begin
            if (op_scale > acc_scale) begin
                big_s = op_sgn;   big_sc = op_scale;  big_m = op_mant;
                sml_s = acc_sgn;  sml_sc = acc_scale; sml_m = acc_mant;
            end
            diff       = {big_sc[9], big_sc} - {sml_sc[9], sml_sc};
            al_sa_d    = big_s;
            al_sb_d    = sml_s;
            al_scale_d = big_sc;
            al_ma_d    = big_m;
            if (diff >= 11'd254) begin
                al_mb_d     = '0;
                al_sticky_d = 1'b1;
            end else begin
                ext         = {sml_m, {MW{1'b0}}} >> diff;
                al_mb_d     = ext[2*MW-1:MW];
                al_sticky_d = acc_sticky | (|ext[MW-1:0]);
            end
        end
    end

    // ---------------- ADD ----------------
    always_comb begin
        ad_sgn_d = al_sa;
        ad_sum_d = {1'b0, al_ma} + {1'b0, al_mb};
        if (al_sa != al_sb) begin
            if (al_ma >= al_mb) begin
                ad_sgn_d = al_sa;
                ad_sum_d = {1'b0, al_ma - al_mb};
            end else begin
                ad_sgn_d = al_sb;
                ad_sum_d = {1'b0, al_mb - al_ma};
            end
        end
    end

    // ---------------- NORM ----------------
    always_comb begin
        n_sgn    = ad_sgn;
        n_inf    = ad_inf;
        n_zero   = 1'b0;
        n_sticky = ad_sticky;
        n_scale  = {{2{ad_scale[9]}}, ad_scale};
        n_mant   = ad_sum[MW-1:0];
        n_lz     = '0;

        if (ad_sum[MW]) begin
            n_mant   = ad_sum[MW:1];
            n_sticky = ad_sticky | ad_sum[0];
            n_scale  = n_scale + 12'sd1;
        end else if (ad_sum == '0) begin
            n_zero  = 1'b1;
            n_sgn   = 1'b0;
            n_scale = '0;
            n_mant  = '0;
        end else begin
            n_lz    = lzc(ad_sum[MW-1:0]);
            n_mant  = ad_sum[MW-1:0] << n_lz;
            n_scale = n_scale - $signed({3'b000, n_lz});
        end

        if (!n_zero) begin
            if (n_scale > 12'sd511) begin
                n_scale  = 12'sd511;
                n_mant   = '1;
                n_sticky = 1'b1;
            end else if (n_scale < -12'sd512) begin
                n_scale  = -12'sd512;
                n_mant   = {1'b1, {FBITS_ACCUM{1'b0}}};
                n_sticky = 1'b1;
            end
        end

        // inf dominates and never reads as zero
        if (n_inf) n_zero = 1'b0;
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_sgn    <= 1'b0;
            acc_scale  <= '0;
            acc_mant   <= '0;
            acc_inf    <= 1'b0;
            acc_zero   <= 1'b1;
            acc_sticky <= 1'b0;
            op_last    <= 1'b0;
        end else begin
            if (accept) begin
                op_sgn   <= bus.in_data[W-1];
                op_scale <= bus.in_data[W-2:SC_LO];
                // a zero-flagged operand carries no magnitude
                op_mant  <= bus.in_data[0] ? '0 : {1'b1, bus.in_data[SC_LO-1:2]};
                op_inf   <= bus.in_data[1];
                op_zero  <= bus.in_data[0];
                op_last  <= bus.in_last;
            end
            if (state == NORM) begin
                acc_sgn    <= n_sgn;
                acc_scale  <= n_scale[9:0];
                acc_mant   <= n_mant;
                acc_inf    <= n_inf;
                acc_zero   <= n_zero;
                acc_sticky <= n_sticky;
            end
            if (state == OUT && bus.out_ready) begin
                acc_sgn    <= 1'b0;
                acc_scale  <= '0;
                acc_mant   <= '0;
                acc_inf    <= 1'b0;
                acc_zero   <= 1'b1;
                acc_sticky <= 1'b0;
            end
        end
    end

    // pipeline holding registers: only read in the stage after they load
    always_ff @(posedge clk) begin
        if (state == ALIGN) begin
            al_sa     <= al_sa_d;
            al_sb     <= al_sb_d;
            al_scale  <= al_scale_d;
            al_ma     <= al_ma_d;
            al_mb     <= al_mb_d;
            al_inf    <= al_inf_d;
            al_sticky <= al_sticky_d;
        end
        if (state == ADD) begin
            ad_sgn    <= ad_sgn_d;
            ad_sum    <= ad_sum_d;
            ad_scale  <= al_scale;
            ad_inf    <= al_inf;
            ad_sticky <= al_sticky;
        end
    end

endmodule

// File: tb/tb_posit_accum_prod_es3.sv
module tb_posit_accum_prod_es3;

    logic clk = 1'b0;
    logic reset;

    posit_accum_prod_es3_if bus();

    posit_accum_prod_es3 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [264:0] a;
        logic [264:0] b;
        logic         two_ops;
        logic [264:0] exp_d;
        logic [264:0] mask;
        logic         exp_tr;
        string        name;
    } vec_t;

    typedef struct {
        logic [264:0] d;
        logic [264:0] m;
        logic         tr;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[9];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [264:0] mk(input logic s, input logic [9:0] sc,
                                        input logic [251:0] fr, input logic inf,
                                        input logic z);
        return {s, sc, fr, inf, z};
    endfunction

    task automatic chk(input string nm, input logic [264:0] act, input logic [264:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [264:0] d, input logic last);
        int n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 265'(n), 265'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // result must appear 4 cycles after the final accept
    task automatic wait_out(input string nm);
        int  lat = 1;
        sb_t e;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, 265'(lat), 265'd4);
        e = sb.pop_front();
        chk({nm, "_data"}, bus.out_data & e.m, e.d & e.m);
        chk({nm, "_trunc"}, 265'(bus.out_truncated), 265'(e.tr));
    endtask

    task automatic handshake(input string nm);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({nm, "_hs_valid"}, 265'(bus.out_valid), 265'd0);
        chk({nm, "_hs_ready"}, 265'(bus.in_ready), 265'd1);
        chk({nm, "_hs_clear"}, bus.out_data, 265'h1);
    endtask

    task automatic run_vec(input vec_t v);
        sb.push_back('{d: v.exp_d, m: v.mask, tr: v.exp_tr});
        if (v.two_ops) send(v.a, 1'b0);
        send(v.b, 1'b1);
        wait_out(v.name);
        handshake(v.name);
    endtask

    initial begin
        logic [264:0] one, neg1, two, tiny, inf_op, half, zop, lsb_op, s511, sat, full;
        logic [264:0] one_half, neg_half, one_lsb;
        logic [251:0] f15, fones;

        f15    = 252'd1 << 251;
        fones  = '1;
        full   = '1;
        one    = mk(1'b0, 10'd0,   252'd0, 1'b0, 1'b0);
        neg1   = mk(1'b1, 10'd0,   252'd0, 1'b0, 1'b0);
        two    = mk(1'b0, 10'd1,   252'd0, 1'b0, 1'b0);
        tiny   = mk(1'b0, 10'd724, 252'd0, 1'b0, 1'b0);   // scale -300
        inf_op = mk(1'b0, 10'd0,   252'd0, 1'b1, 1'b0);
        half   = mk(1'b0, 10'h3FF, 252'd0, 1'b0, 1'b0);   // scale -1
        zop    = mk(1'b0, 10'd0,   252'd0, 1'b0, 1'b1);
        lsb_op = mk(1'b0, 10'd772, 252'd1, 1'b0, 1'b0);   // scale -252, frac lsb set
        s511   = mk(1'b0, 10'd511, 252'd0, 1'b0, 1'b0);
        sat    = mk(1'b0, 10'd511, fones,  1'b0, 1'b0);
        one_half = mk(1'b0, 10'd0,   f15,   1'b0, 1'b0);
        neg_half = mk(1'b1, 10'h3FF, 252'd0, 1'b0, 1'b0);
        one_lsb  = mk(1'b0, 10'd0,   252'd1, 1'b0, 1'b0);

        //          a       b      two   expected   mask        tr    name
        vecs[0] = '{one,    one,   1'b1, two,       full,       1'b0, "one_plus_one"};
        vecs[1] = '{one,    neg1,  1'b1, 265'h1,    full,       1'b0, "one_minus_one"};
        vecs[2] = '{one,    tiny,  1'b1, one,       full,       1'b1, "one_plus_tiny"};
        vecs[3] = '{inf_op, one,   1'b1, 265'h2,    265'h3,     1'b0, "inf_plus_one"};
        vecs[4] = '{one,    half,  1'b1, one_half,  full,       1'b0, "one_plus_half"};
        vecs[5] = '{neg1,   half,  1'b1, neg_half,  full,       1'b0, "neg1_plus_half"};
        vecs[6] = '{one,    zop,   1'b1, one,       full,       1'b0, "one_plus_zero"};
        vecs[7] = '{one,    lsb_op,1'b1, one_lsb,   full,       1'b1, "align_252"};
        vecs[8] = '{one,    one,   1'b0, one,       full,       1'b0, "single_one"};

        reset         = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 265'(bus.in_ready), 265'd0);
        chk("rst_out_valid", 265'(bus.out_valid), 265'd0);
        chk("rst_out_data", bus.out_data, 265'h1);
        chk("rst_trunc", 265'(bus.out_truncated), 265'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 265'(bus.in_ready), 265'd1);
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // held result under back-pressure, then a clean follow-up sum
        sb.push_back('{d: one_half, m: full, tr: 1'b0});
        send(one_half, 1'b1);
        wait_out("stall");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_data", bus.out_data, one_half);
            chk("stall_valid", 265'(bus.out_valid), 265'd1);
            chk("stall_in_ready", 265'(bus.in_ready), 265'd0);
        end
        handshake("stall");
        sb.push_back('{d: one, m: full, tr: 1'b0});
        send(one, 1'b1);
        wait_out("after_stall");
        handshake("after_stall");

        // reset while the operand sits in ADD
        send(one, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_in_ready", 265'(bus.in_ready), 265'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_wait", 265'(bus.in_ready), 265'd1);
        chk("midrst_valid", 265'(bus.out_valid), 265'd0);
        chk("midrst_data", bus.out_data, 265'h1);
        chk("midrst_trunc", 265'(bus.out_truncated), 265'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_out", 265'(bus.out_valid), 265'd0);
        end

        // scale overflow saturates
        sb.push_back('{d: sat, m: full, tr: 1'b1});
        send(s511, 1'b0);
        send(s511, 1'b1);
        wait_out("saturate");
        handshake("saturate");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/posit_accum_prod_es3.md
POSIT_ACCUM_PROD_ES3 -- requirements
Module: posit_accum_prod_es3

Interface
REQ-001 Package constants from posit_defines_es3 SHALL be used as follows: POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES3 is 265, FBITS_ACCUM is 252 and ES is 3.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be synchronous and active-high.
REQ-004 in_data  input  265  operand: [264] sgn, [263:254] scale (two's complement), [253:2] fraction (hidden 1 not stored), [1] inf, [0] zero.
REQ-005 in_valid  input  1  operand valid.
REQ-006 in_last  input  1  marks the final operand of a dot product; sampled together with in_data.
REQ-007 in_ready  output  1  block accepts an operand.
REQ-008 out_data  output  265  accumulated sum in the same layout as in_data.
REQ-009 out_truncated  output  1  sticky flag set when any nonzero bit was discarded during accumulation.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream normalizer consumes the result.

Function
REQ-012 The FSM SHALL have the states WAIT, ALIGN, ADD, NORM and OUT.
REQ-013 in_ready SHALL be (state==WAIT) & ~reset; an operand SHALL be accepted in any cycle c with in_valid & in_ready.
REQ-014 On acceptance the FSM SHALL pass through ALIGN in cycle c+1, ADD in c+2 and NORM in c+3; in cycle c+4 it SHALL be in OUT if in_last was set, otherwise in WAIT.
REQ-015 Throughput SHALL be one operand per 4 cycles.
REQ-016 The accumulator SHALL hold sgn, scale[9:0], mantissa {1,fraction}, inf, zero and sticky; when idle it SHALL be zero=1, all other fields 0.
REQ-017 ALIGN: the operand with the smaller scale SHALL be right-shifted by the scale difference; shifted-out bits SHALL be ORed into sticky.
REQ-018 ALIGN, large difference: if the difference is 254 or more, the smaller operand SHALL contribute only sticky (sticky |= 1).
REQ-019 ALIGN, zero operand: a zero-flagged operand SHALL contribute nothing, and the other operand SHALL pass exactly.
REQ-020 ADD, equal signs: mantissas SHALL be added with a 1-bit carry.
REQ-021 ADD, unequal signs: the larger magnitude (compared by scale, then mantissa) minus the smaller SHALL be formed, and the result SHALL take the larger operand's sign.
REQ-022 NORM, carry: on carry, the result SHALL shift right 1 with scale+1, and the dropped bit SHALL be ORed into sticky.
REQ-023 NORM, otherwise: the result SHALL shift left by the leading-zero count with scale reduced by that count.
REQ-024 NORM, exact zero: an exact-zero result SHALL set zero=1, sgn=0, scale=0 and fraction=0.
REQ-025 Scale overflow above +511 SHALL saturate to scale 511 with fraction all ones and sticky=1.
REQ-026 Scale underflow below -512 SHALL clamp to scale -512 with fraction 0 and sticky=1.
REQ-027 Inf: if either addend has inf=1, the result SHALL be inf=1, zero=0, and it SHALL stay inf until output.
REQ-028 OUT: out_valid=1; out_data SHALL be the accumulator fields and out_truncated the sticky flag, both held stable until out_ready=1.
REQ-029 On the cycle out_valid & out_ready, the accumulator SHALL clear to zero, sticky SHALL clear and the next state SHALL be WAIT; in_ready SHALL be 0 throughout OUT.
REQ-030 in_valid in a non-WAIT state SHALL be ignored.
REQ-031 out_valid SHALL never assert outside OUT.

Reset
REQ-032 Reset, in any state including mid-operation, SHALL force WAIT, clear the accumulator (zero=1), set out_valid=0 and out_truncated=0, and discard the in-flight operand.
REQ-033 out_data SHALL read 265'h1 after reset.
REQ-034 in_ready SHALL be 0 during the reset cycle and 1 in the first cycle after reset deasserts.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
- 1.0 (sgn0, scale0, frac0), then 1.0 with in_last -> out_valid in c+4 after the 2nd accept; scale=1, frac=0, zero=0, out_truncated=0.
- 1.0, then -1.0 with last -> zero=1, sgn=0, scale=0, out_truncated=0.
- 1.0, then scale=-300 frac=0 with last -> out equals 1.0 exactly, out_truncated=1.
- inf=1 operand, then 1.0 with last -> out inf=1, zero=0.
- Single 1.5 (frac MSB=1) with last, out_ready low 5 cycles -> out_data and out_valid stable, in_ready=0; after handshake in_ready=1 and a following single 1.0 with last yields exactly 1.0.
- Reset asserted while in ADD -> next cycle WAIT, out_valid=0; then a single scale=511 operand plus another scale=511 operand with last -> scale=511, fraction all ones, out_truncated=1.
